// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Fixed-latency data memory with a downward-growing stack port.
// Revision    : 1.0
// ============================================================================
module data_mem_responder #(
    parameter int ADDR_W = 12,
    parameter int LAT    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] address,
    input  logic [15:0] wdata,
    output logic        rsp_valid,
    output logic [15:0] rdata,
    output logic        err,
    output logic [31:0] sp
);

    localparam int              c_depth  = 1 << ADDR_W;
    localparam logic [2:0]      c_last   = 3'(LAT - 1);
    localparam logic [ADDR_W-1:0] c_sp_top = {ADDR_W{1'b1}};
    localparam logic [1:0]      c_op_rd   = 2'd0;
    localparam logic [1:0]      c_op_wr   = 2'd1;
    localparam logic [1:0]      c_op_push = 2'd2;
    localparam logic [1:0]      c_op_pop  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [2:0]          r_cnt;
    logic [1:0]          r_op;
    logic [ADDR_W-1:0]   r_addr;
    logic [15:0]         r_wdata;
    logic [ADDR_W-1:0]   r_sp;
    logic [15:0]         r_rdata;
    logic                r_err;
    logic [15:0]         r_mem [0:c_depth-1];

    logic [3:0]          w_cmd;
    logic                w_one_cmd;
    logic                w_addr_hi_nz;
    logic                w_legal;
    logic                w_accept;
    logic                w_commit;
    logic [1:0]          w_op;
    logic [ADDR_W-1:0]   w_waddr;
    logic [ADDR_W-1:0]   w_raddr;

    assign w_cmd        = {memRead, memWrite, push, pop};
    assign w_one_cmd    = (w_cmd != 4'd0) && ((w_cmd & (w_cmd - 4'd1)) == 4'd0);
    assign w_addr_hi_nz = |(address >> ADDR_W);
    assign w_legal      = w_one_cmd
                        && !((memRead || memWrite) && w_addr_hi_nz)
                        && !(push && (r_sp == '0))
                        && !(pop && (r_sp == c_sp_top));
    assign w_accept     = req_valid && (r_state == S_IDLE);
    assign w_commit     = (r_state == S_BUSY) && (r_cnt == c_last);

    always_comb begin
        w_op = c_op_rd;
        if (memWrite)  w_op = c_op_wr;
        if (push)      w_op = c_op_push;
        if (pop)       w_op = c_op_pop;
    end

    // Stack grows downward: push stores at sp, pop reads the slot above sp.
    assign w_waddr = (r_op == c_op_push) ? r_sp : r_addr;
    assign w_raddr = (r_op == c_op_pop) ? (r_sp + 1'b1) : r_addr;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req_valid) w_next = w_legal ? S_BUSY : S_RESP;
            S_BUSY:  if (r_cnt == c_last) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            r_op    <= c_op_rd;
            r_addr  <= '0;
            r_wdata <= 16'd0;
            r_sp    <= c_sp_top;
            r_rdata <= 16'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op    <= w_op;
                r_addr  <= address[ADDR_W-1:0];
                r_wdata <= wdata;
                r_cnt   <= 3'd0;
                if (!w_legal) begin
                    r_rdata <= 16'd0;
                    r_err   <= 1'b1;
                end
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt + 3'd1;
            end
            if (w_commit) begin
                r_err   <= 1'b0;
                r_rdata <= 16'd0;
                case (r_op)
                    c_op_rd:   r_rdata <= r_mem[w_raddr];
                    c_op_push: r_sp    <= r_sp - 1'b1;
                    c_op_pop: begin
                        r_sp    <= r_sp + 1'b1;
                        r_rdata <= r_mem[w_raddr];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Storage is not reset; a reset edge still blocks a pending commit.
    always_ff @(posedge clk) begin
        if (rst_n && w_commit && ((r_op == c_op_wr) || (r_op == c_op_push)))
            r_mem[w_waddr] <= r_wdata;
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rdata     = r_rdata;
    assign err       = r_err;
    assign sp        = {{(32-ADDR_W){1'b0}}, r_sp};

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Self-checking bench for data_mem_responder with random model.
// Revision    : 1.0
// ============================================================================
module tb_data_mem_responder;

    localparam int ADDR_W = 12;
    localparam int LAT    = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        memRead = 1'b0, memWrite = 1'b0, push = 1'b0, pop = 1'b0;
    logic [31:0] address = 32'd0;
    logic [15:0] wdata = 16'd0;
    logic        req_ready, rsp_valid, err;
    logic [15:0] rdata;
    logic [31:0] sp;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] mref  [0:DEPTH-1];
    bit          known [0:DEPTH-1];
    int          ref_sp;

    data_mem_responder #(.ADDR_W(ADDR_W), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .memRead(memRead), .memWrite(memWrite), .push(push), .pop(pop),
        .address(address), .wdata(wdata), .rsp_valid(rsp_valid),
        .rdata(rdata), .err(err), .sp(sp)
    );

    always #5 clk = ~clk;

    // Transaction driver: starts and ends mid-cycle (at a falling edge).
    task automatic send(input logic [3:0] cmd, input logic [31:0] a, input logic [15:0] wd,
                        output int lat, output logic [15:0] rd, output logic e, output logic tail_ok);
        int w;
        {memRead, memWrite, push, pop} = cmd;
        address = a; wdata = wd; req_valid = 1'b1;
        lat = 0; rd = 16'd0; e = 1'b0; tail_ok = 1'b0; w = 0;
        while (!req_ready && w < 20) begin @(negedge clk); w++; end
        @(posedge clk); #1;
        req_valid = 1'b0; {memRead, memWrite, push, pop} = 4'b0000;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rsp_valid) begin lat = k; rd = rdata; e = err; break; end
        end
        @(negedge clk);
        tail_ok = !rsp_valid && req_ready;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        vectors++; if (rdata !== 16'h0) begin miscompares++; $display("FAIL reset_rdata: got %h expected 0000", rdata); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", err); end
        vectors++; if (sp !== 32'h0000_0FFF) begin miscompares++; $display("FAIL reset_sp: got %h expected 00000fff", sp); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        int lat; logic [15:0] rd; logic e, t;
        send(4'b0100, 32'h10, 16'hBEEF, lat, rd, e, t);
        vectors++; if (lat !== LAT + 1) begin miscompares++; $display("FAIL wr_latency: got %0d expected %0d", lat, LAT + 1); end
        vectors++; if (e !== 1'b0 || rd !== 16'h0) begin miscompares++; $display("FAIL wr_resp: got err=%b rdata=%h expected err=0 rdata=0000", e, rd); end
        vectors++; if (t !== 1'b1) begin miscompares++; $display("FAIL wr_single_pulse: got %b expected 1", t); end
        send(4'b1000, 32'h10, 16'h0, lat, rd, e, t);
        vectors++; if (lat !== LAT + 1) begin miscompares++; $display("FAIL rd_latency: got %0d expected %0d", lat, LAT + 1); end
        vectors++; if (e !== 1'b0 || rd !== 16'hBEEF) begin miscompares++; $display("FAIL rd_data: got err=%b rdata=%h expected err=0 rdata=beef", e, rd); end
    endtask

    task automatic test_stack();
        int lat; logic [15:0] rd; logic e, t;
        do_reset();
        @(negedge clk);
        send(4'b0010, 32'h0, 16'h1111, lat, rd, e, t);
        vectors++; if (sp !== 32'hFFE || e !== 1'b0) begin miscompares++; $display("FAIL push1: got sp=%h err=%b expected sp=ffe err=0", sp, e); end
        send(4'b0010, 32'h0, 16'h2222, lat, rd, e, t);
        vectors++; if (sp !== 32'hFFD) begin miscompares++; $display("FAIL push2: got sp=%h expected ffd", sp); end
        send(4'b0001, 32'h0, 16'h0, lat, rd, e, t);
        vectors++; if (sp !== 32'hFFE || rd !== 16'h2222 || e !== 1'b0) begin miscompares++; $display("FAIL pop1: got sp=%h rdata=%h err=%b expected sp=ffe rdata=2222 err=0", sp, rd, e); end
        send(4'b0001, 32'h0, 16'h0, lat, rd, e, t);
        vectors++; if (sp !== 32'hFFF || rd !== 16'h1111) begin miscompares++; $display("FAIL pop2: got sp=%h rdata=%h expected sp=fff rdata=1111", sp, rd); end
        vectors++; if (lat !== LAT + 1) begin miscompares++; $display("FAIL pop_latency: got %0d expected %0d", lat, LAT + 1); end
    endtask

    task automatic test_illegal();
        int lat; logic [15:0] rd; logic e, t;
        do_reset();
        @(negedge clk);
        send(4'b0001, 32'h0, 16'h0, lat, rd, e, t);
        vectors++; if (lat !== 1 || e !== 1'b1 || rd !== 16'h0) begin miscompares++; $display("FAIL pop_empty: got lat=%0d err=%b rdata=%h expected lat=1 err=1 rdata=0000", lat, e, rd); end
        vectors++; if (sp !== 32'hFFF) begin miscompares++; $display("FAIL pop_empty_sp: got %h expected fff", sp); end
        send(4'b1000, 32'h0001_0000, 16'h0, lat, rd, e, t);
        vectors++; if (lat !== 1 || e !== 1'b1) begin miscompares++; $display("FAIL rd_high_addr: got lat=%0d err=%b expected lat=1 err=1", lat, e); end
        send(4'b0000, 32'h0, 16'h0, lat, rd, e, t);
        vectors++; if (e !== 1'b1 || t !== 1'b1) begin miscompares++; $display("FAIL no_cmd: got err=%b tail=%b expected err=1 tail=1", e, t); end
        send(4'b0100, 32'h30, 16'h1234, lat, rd, e, t);
        send(4'b1010, 32'h30, 16'hDEAD, lat, rd, e, t);
        vectors++; if (lat !== 1 || e !== 1'b1 || rd !== 16'h0) begin miscompares++; $display("FAIL multi_cmd: got lat=%0d err=%b rdata=%h expected lat=1 err=1 rdata=0000", lat, e, rd); end
        send(4'b1000, 32'h30, 16'h0, lat, rd, e, t);
        vectors++; if (rd !== 16'h1234 || sp !== 32'hFFF) begin miscompares++; $display("FAIL multi_cmd_effect: got rdata=%h sp=%h expected rdata=1234 sp=fff", rd, sp); end
    endtask

    task automatic test_reset_busy();
        int lat, pulses; logic [15:0] rd; logic e, t;
        send(4'b0100, 32'h20, 16'hAAAA, lat, rd, e, t);
        memWrite = 1'b1; address = 32'h20; wdata = 16'h5555; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; memWrite = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin @(negedge clk); if (rsp_valid) pulses++; end
        vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL abandon_no_resp: got %0d pulses expected 0", pulses); end
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL abandon_ready: got %b expected 1", req_ready); end
        send(4'b1000, 32'h20, 16'h0, lat, rd, e, t);
        vectors++; if (rd !== 16'hAAAA || e !== 1'b0) begin miscompares++; $display("FAIL abandon_mem: got rdata=%h err=%b expected rdata=aaaa err=0", rd, e); end
    endtask

    task automatic test_back_to_back();
        int acc [3];
        int n, pulses, bad;
        n = 0; pulses = 0; bad = 0;
        memRead = 1'b1; address = 32'h10; req_valid = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (req_valid && req_ready) begin if (n < 3) acc[n] = c; n++; end
            if (rsp_valid) begin
                pulses++;
                if (rdata !== 16'hBEEF || c != 4 * (pulses - 1) + LAT + 1) bad++;
            end
            @(posedge clk); #1;
            if (n == 3) begin req_valid = 1'b0; memRead = 1'b0; end
            @(negedge clk);
        end
        vectors++; if (n !== 3 || acc[0] !== 0 || acc[1] !== 4 || acc[2] !== 8) begin miscompares++; $display("FAIL b2b_accept: got n=%0d at %0d,%0d,%0d expected 3 at 0,4,8", n, acc[0], acc[1], acc[2]); end
        vectors++; if (pulses !== 3 || bad !== 0) begin miscompares++; $display("FAIL b2b_resp: got %0d pulses %0d bad expected 3 pulses 0 bad", pulses, bad); end
    endtask

    task automatic test_random();
        int lat, a, exp_lat; logic [15:0] rd, wd, exp_rd; logic e, t, illegal, chk_rd;
        logic [3:0] cmd; logic [31:0] addr;
        do_reset();
        @(negedge clk);
        ref_sp = DEPTH - 1;
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) < 8) cmd = 4'(1 << $urandom_range(0, 3));
            else cmd = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: addr = 32'($urandom_range(0, 15));
                6, 7, 8:          addr = 32'($urandom_range(DEPTH - 8, DEPTH - 1));
                default:          addr = 32'h0001_0000 | 32'($urandom_range(0, 15));
            endcase
            wd = 16'($urandom);
            illegal = ($countones(cmd) != 1)
                   || ((cmd[3] || cmd[2]) && addr >= DEPTH)
                   || (cmd[1] && ref_sp == 0)
                   || (cmd[0] && ref_sp == DEPTH - 1);
            exp_rd = 16'h0; chk_rd = 1'b1;
            exp_lat = illegal ? 1 : LAT + 1;
            if (!illegal) begin
                a = int'(addr);
                if (cmd[3]) begin exp_rd = mref[a]; chk_rd = known[a]; end
                else if (cmd[2]) begin mref[a] = wd; known[a] = 1'b1; end
                else if (cmd[1]) begin mref[ref_sp] = wd; known[ref_sp] = 1'b1; ref_sp--; end
                else begin ref_sp++; exp_rd = mref[ref_sp]; chk_rd = known[ref_sp]; end
            end
            send(cmd, addr, wd, lat, rd, e, t);
            vectors++;
            if (lat !== exp_lat || e !== illegal || t !== 1'b1 || sp !== 32'(ref_sp) || (chk_rd && rd !== exp_rd)) begin
                miscompares++;
                $display("FAIL random_%0d cmd=%b addr=%h: got lat=%0d err=%b tail=%b sp=%h rdata=%h expected lat=%0d err=%b tail=1 sp=%h rdata=%h",
                         n, cmd, addr, lat, e, t, sp, rd, exp_lat, illegal, ref_sp, exp_rd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_stack();
        test_illegal();
        test_reset_busy();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, giving 2^ADDR_W words of 16-bit data storage.
REQ-002 The block SHALL have parameter LAT, default 2, range 1..7, giving the number of BUSY cycles per accepted access.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 The block SHALL have port req_valid, input, 1, the initiator presents a request.
REQ-006 The block SHALL have port req_ready, output, 1, the block can accept a request.
REQ-007 The block SHALL have ports memRead, memWrite, push and pop, input, 1 each, the request command bits.
REQ-008 The block SHALL have port address, input, 32, the word address for memRead/memWrite, ignored for push/pop.
REQ-009 The block SHALL have port wdata, input, 16, the store or push data.
REQ-010 The block SHALL have port rsp_valid, output, 1, a one-cycle response strobe.
REQ-011 The block SHALL have port rdata, output, 16, the load or pop data, valid with rsp_valid.
REQ-012 The block SHALL have port err, output, 1, the error flag, valid with rsp_valid.
REQ-013 The block SHALL have port sp, output, 32, the current stack pointer, zero-extended from ADDR_W bits.

Function
REQ-014 The block SHALL implement FSM states IDLE, BUSY and RESP; req_ready SHALL be 1 only in IDLE.
REQ-015 A request SHALL be accepted at the edge where req_valid=1 and req_ready=1; command, address and wdata SHALL be captured at that edge.
REQ-016 Accepting a legal request SHALL move IDLE->BUSY, stay in BUSY exactly LAT cycles, then move to RESP, hold RESP for one cycle, and return to IDLE.
REQ-017 With acceptance in cycle T, rsp_valid SHALL be 1 only in cycle T+LAT+1, and req_ready SHALL return to 1 in cycle T+LAT+2.
REQ-018 The memory effect (store, or sampling of rdata) SHALL commit at the edge ending the last BUSY cycle.
REQ-019 memRead SHALL return mem[address[ADDR_W-1:0]] on rdata.
REQ-020 memWrite SHALL write wdata to mem[address[ADDR_W-1:0]], and rdata SHALL be 0.
REQ-021 push SHALL write wdata to mem[sp], then sp SHALL become sp-1; rdata SHALL be 0.
REQ-022 pop SHALL set sp to sp+1, then return mem[new sp] on rdata.
REQ-023 A request SHALL be illegal if more than one of memRead/memWrite/push/pop is 1, or none is 1.
REQ-024 A request SHALL be illegal if memRead or memWrite is set and address[31:ADDR_W] is non-zero.
REQ-025 A push SHALL be illegal when sp=0 (overflow).
REQ-026 A pop SHALL be illegal when sp=2^ADDR_W-1 (underflow/empty).
REQ-027 An illegal request SHALL go IDLE->RESP directly, with rsp_valid in cycle T+1, err=1, rdata=0, and no change to memory or sp.
REQ-028 For legal requests err SHALL be 0; outside RESP, rsp_valid SHALL be 0 and rdata/err SHALL hold their last values.
REQ-029 Request inputs SHALL be ignored while req_ready=0.
REQ-030 Back-to-back requests SHALL be allowed: a request held valid SHALL be accepted in the first IDLE cycle.
REQ-031 sp SHALL change only at the commit edge of a legal push or pop.

Reset
REQ-032 While rst_n=0 at an edge, the block SHALL set state=IDLE, req_ready=1, rsp_valid=0, rdata=0, err=0 and sp=2^ADDR_W-1 (0x00000FFF at default).
REQ-033 Reset SHALL NOT clear memory contents.
REQ-034 A reset asserted during BUSY SHALL abandon the access: no memory write, no sp change and no response.

Verification
REQ-035 The bench SHALL cover memWrite address=0x10 wdata=0xBEEF accepted cycle 0, then memRead address=0x10 -> write response in cycle 3, read rsp_valid in cycle 7 with rdata=0xBEEF, err=0.
REQ-036 The bench SHALL cover push 0x1111, push 0x2222, pop, pop after reset -> sp 0xFFF->0xFFE->0xFFD->0xFFE->0xFFF, with pop rdata 0x2222 then 0x1111.
REQ-037 The bench SHALL cover pop immediately after reset -> rsp_valid in cycle T+1, err=1, sp stays 0xFFF; and memRead with address=0x00010000 -> err=1.
REQ-038 The bench SHALL cover a request with memRead=1 and push=1 -> err=1, and a later read shows memory unchanged and sp unchanged.
REQ-039 The bench SHALL cover memWrite address=0x20 wdata=0xAAAA, then a second memWrite 0x5555 with rst_n=0 in its first BUSY cycle -> no response to the second write, req_ready=1 after reset, and reading 0x20 returns 0xAAAA.
REQ-040 The bench SHALL cover req_valid held high across 3 reads with LAT=2 -> acceptances in cycles 0, 4 and 8, and exactly one rsp_valid pulse per read.
